// File: rtl/raster_stamp_packer.sv
// rtl/raster_stamp_packer.sv - packs single raster stamps into NUM_LANES-wide bus requests, then answers done.
// Optional RASTER_STAMP_PERF_EN adds stamp/request/stall counters.
module raster_stamp_packer #(
   parameter int NUM_LANES   = 4,
   parameter int STAMP_WIDTH = 128,
   parameter int MASK_WIDTH  = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             stamp_valid,
   output logic                             stamp_ready,
   input  logic [STAMP_WIDTH-1:0]           stamp_data,
   input  logic [MASK_WIDTH-1:0]            stamp_mask,
   input  logic                             stamps_end,
   output logic                             req_valid,
   input  logic                             req_ready,
   output logic [NUM_LANES*STAMP_WIDTH-1:0] req_data,
   output logic [NUM_LANES*MASK_WIDTH-1:0]  req_mask,
   output logic                             req_done,
   output logic                             busy
`ifdef RASTER_STAMP_PERF_EN
   ,
   output logic [31:0]                      perf_stamps,
   output logic [31:0]                      perf_reqs,
   output logic [31:0]                      perf_stalls
`endif
);

   localparam int CW = $clog2(NUM_LANES + 1);
   localparam logic [CW-1:0] FULL = CW'(NUM_LANES);
   localparam logic [CW-1:0] LAST = CW'(NUM_LANES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_t;

   state_t                           state, state_next;
   logic [CW-1:0]                    count;
   logic [NUM_LANES*STAMP_WIDTH-1:0] fill_data, pack_data;
   logic [NUM_LANES*MASK_WIDTH-1:0]  fill_mask, pack_mask;
   logic                             accept, out_free, group_full, do_xfer;

   always_comb begin
      stamp_ready = (state == ST_RUN) && (count < FULL);
      accept      = stamp_valid && stamp_ready;
      out_free    = !req_valid || req_ready;
      // The stamp completing a group goes straight to the output, so it is visible the next cycle.
      group_full  = (count == FULL) || (accept && (count == LAST));
      do_xfer     = out_free && (state != ST_DONE) &&
                    (group_full || ((state == ST_FLUSH) && (count != '0)));
      busy        = (state != ST_DONE);

      pack_data = '0;
      pack_mask = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (CW'(i) < count) begin
            pack_data[i*STAMP_WIDTH +: STAMP_WIDTH] = fill_data[i*STAMP_WIDTH +: STAMP_WIDTH];
            pack_mask[i*MASK_WIDTH +: MASK_WIDTH]   = fill_mask[i*MASK_WIDTH +: MASK_WIDTH];
         end else if (accept && (CW'(i) == count)) begin
            pack_data[i*STAMP_WIDTH +: STAMP_WIDTH] = stamp_data;
            pack_mask[i*MASK_WIDTH +: MASK_WIDTH]   = stamp_mask;
         end
      end

      state_next = state;
      case (state)
         ST_RUN:   if (stamps_end) state_next = ST_FLUSH;
         ST_FLUSH: if ((count == '0) && out_free) state_next = ST_DONE;
         ST_DONE:  if (start) state_next = ST_RUN;
         default:  state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_RUN;
         count     <= '0;
         fill_data <= '0;
         fill_mask <= '0;
         req_valid <= 1'b0;
         req_data  <= '0;
         req_mask  <= '0;
         req_done  <= 1'b0;
      end else begin
         state <= state_next;

         if (do_xfer || ((state == ST_DONE) && start))
            count <= '0;
         else if (accept)
            count <= count + ONE;

         for (int i = 0; i < NUM_LANES; i++) begin
            if (accept && !do_xfer && (CW'(i) == count)) begin
               fill_data[i*STAMP_WIDTH +: STAMP_WIDTH] <= stamp_data;
               fill_mask[i*MASK_WIDTH +: MASK_WIDTH]   <= stamp_mask;
            end
         end

         if (do_xfer) begin
            req_valid <= 1'b1;
            req_data  <= pack_data;
            req_mask  <= pack_mask;
            req_done  <= 1'b0;
         end else if ((state == ST_FLUSH) && (state_next == ST_DONE)) begin
            req_valid <= 1'b1;
            req_data  <= '0;
            req_mask  <= '0;
            req_done  <= 1'b1;
         end else if ((state == ST_DONE) && start) begin
            req_valid <= 1'b0;
            req_done  <= 1'b0;
         end else if (req_valid && req_ready && (state != ST_DONE)) begin
            req_valid <= 1'b0;
         end
      end
   end

`ifdef RASTER_STAMP_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stamps <= '0;
         perf_reqs   <= '0;
         perf_stalls <= '0;
      end else begin
         if (accept)
            perf_stamps <= perf_stamps + 32'd1;
         if (req_valid && req_ready && !req_done)
            perf_reqs <= perf_reqs + 32'd1;
         if (req_valid && !req_ready && !req_done)
            perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_raster_stamp_packer.sv
// tb/tb_raster_stamp_packer.sv - directed self-checking bench for raster_stamp_packer.
module tb_raster_stamp_packer;

   logic         clk, reset, start, stamp_valid, stamp_ready, stamps_end;
   logic [127:0] stamp_data;
   logic [3:0]   stamp_mask;
   logic         req_valid, req_ready, req_done, busy;
   logic [511:0] req_data;
   logic [15:0]  req_mask;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [511:0] d;
      logic [15:0]  m;
      logic         dn;
   } rsp_t;
   rsp_t q[$];

   raster_stamp_packer #(.NUM_LANES(4), .STAMP_WIDTH(128), .MASK_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .start(start),
      .stamp_valid(stamp_valid), .stamp_ready(stamp_ready),
      .stamp_data(stamp_data), .stamp_mask(stamp_mask), .stamps_end(stamps_end),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .req_mask(req_mask), .req_done(req_done), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (!reset && req_valid && req_ready)
         q.push_back('{d: req_data, m: req_mask, dn: req_done});

   function automatic logic [127:0] sd(input int k);
      logic [31:0] kk;
      kk = k;
      return {kk, 32'h1234_0000 + kk, 32'hABCD_0000 ^ kk, ~kk};
   endfunction

   function automatic logic [3:0] mk(input int k);
      return 4'((k % 15) + 1);
   endfunction

   function automatic logic [511:0] grp(input int base, input int n);
      logic [511:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[i*128 +: 128] = sd(base + i);
      return r;
   endfunction

   function automatic logic [15:0] gmask(input int base, input int n);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[i*4 +: 4] = mk(base + i);
      return r;
   endfunction

   // Called right after a negedge; returns right after the negedge following the accepting edge.
   task automatic push_stamp(input int k);
      bit ok;
      ok = 1'b0;
      stamp_valid = 1'b1;
      stamp_data  = sd(k);
      stamp_mask  = mk(k);
      for (int t = 0; t < 100 && !ok; t++) begin
         if (stamp_ready) ok = 1'b1;
         @(negedge clk);
      end
      if (!ok) begin
         fails++;
         $display("FAIL push_timeout stamp %0d never accepted", k);
      end
   endtask

   task automatic wait_q(input int n);
      for (int t = 0; t < 300 && q.size() < n; t++) @(negedge clk);
      tests++;
      if (q.size() < n) begin
         fails++;
         $display("FAIL wait_q got %0d requests, required %0d", q.size(), n);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; stamp_valid = 1'b0; stamp_data = '0;
      stamp_mask = '0; stamps_end = 1'b0; req_ready = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid got %b exp 0", req_valid); end
      tests++; if (req_done !== 1'b0) begin fails++; $display("FAIL rst_req_done got %b exp 0", req_done); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_busy got %b exp 1", busy); end
      tests++; if (stamp_ready !== 1'b1) begin fails++; $display("FAIL rst_stamp_ready got %b exp 1", stamp_ready); end
      tests++; if (req_mask !== 16'h0) begin fails++; $display("FAIL rst_req_mask got %h exp 0", req_mask); end
      tests++; if (req_data !== 512'h0) begin fails++; $display("FAIL rst_req_data got %h exp 0", req_data); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      q.delete();
      req_ready = 1'b1;
      for (int k = 0; k < 8; k++) push_stamp(k);
      tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL b2b_second_valid got %b exp 1", req_valid); end
      tests++; if (req_data !== grp(4, 4)) begin fails++; $display("FAIL b2b_second_data got %h exp %h", req_data, grp(4, 4)); end
      stamp_valid = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (q.size() !== 2) begin fails++; $display("FAIL b2b_count got %0d exp 2", q.size()); end
      if (q.size() >= 2) begin
         for (int g = 0; g < 2; g++) begin
            tests++;
            if (q[g].d !== grp(4*g, 4) || q[g].m !== gmask(4*g, 4) || q[g].dn !== 1'b0) begin
               fails++;
               $display("FAIL b2b_req%0d got %h/%h/%b exp %h/%h/0", g, q[g].d, q[g].m, q[g].dn, grp(4*g, 4), gmask(4*g, 4));
            end
         end
      end
      tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle_valid got %b exp 0", req_valid); end
   endtask

   task automatic test_flush;
      q.delete();
      for (int k = 10; k < 15; k++) push_stamp(k);
      stamp_valid = 1'b0;
      stamps_end  = 1'b1;
      wait_q(3);
      req_ready = 1'b0;
      if (q.size() >= 3) begin
         tests++;
         if (q[0].d !== grp(10, 4) || q[0].m !== gmask(10, 4) || q[0].dn !== 1'b0) begin
            fails++; $display("FAIL flush_req0 got %h/%h/%b", q[0].d, q[0].m, q[0].dn);
         end
         tests++;
         if (q[1].d !== grp(14, 1) || q[1].m !== 16'h000F || q[1].dn !== 1'b0) begin
            fails++; $display("FAIL flush_partial got %h/%h/%b exp %h/000f/0", q[1].d, q[1].m, q[1].dn, grp(14, 1));
         end
         tests++;
         if (q[2].d !== 512'h0 || q[2].m !== 16'h0 || q[2].dn !== 1'b1) begin
            fails++; $display("FAIL flush_done got %h/%h/%b exp 0/0/1", q[2].d, q[2].m, q[2].dn);
         end
      end
      repeat (3) @(negedge clk);
      tests++;
      if (req_valid !== 1'b1 || req_done !== 1'b1 || busy !== 1'b0 || stamp_ready !== 1'b0) begin
         fails++;
         $display("FAIL done_hold got v%b d%b busy%b rdy%b exp v1 d1 busy0 rdy0", req_valid, req_done, busy, stamp_ready);
      end
   endtask

   task automatic test_done_repeat;
      q.delete();
      for (int i = 0; i < 3; i++) begin
         req_ready = 1'b1;
         @(negedge clk);
         req_ready = 1'b0;
         @(negedge clk);
      end
      tests++; if (q.size() !== 3) begin fails++; $display("FAIL done_repeat_count got %0d exp 3", q.size()); end
      for (int i = 0; i < q.size(); i++) begin
         tests++;
         if (q[i].dn !== 1'b1 || q[i].m !== 16'h0) begin
            fails++; $display("FAIL done_repeat%0d got dn%b m%h exp dn1 m0", i, q[i].dn, q[i].m);
         end
      end
   endtask

   task automatic test_restart;
      stamps_end = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (req_valid !== 1'b0 || req_done !== 1'b0 || busy !== 1'b1 || stamp_ready !== 1'b1) begin
         fails++;
         $display("FAIL restart got v%b d%b busy%b rdy%b exp v0 d0 busy1 rdy1", req_valid, req_done, busy, stamp_ready);
      end
      q.delete();
      req_ready = 1'b1;
      for (int k = 20; k < 24; k++) push_stamp(k);
      stamp_valid = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (q.size() !== 1) begin
         fails++; $display("FAIL restart_count got %0d exp 1", q.size());
      end else if (q[0].d !== grp(20, 4) || q[0].dn !== 1'b0) begin
         fails++; $display("FAIL restart_data got %h/%b exp %h/0", q[0].d, q[0].dn, grp(20, 4));
      end
   endtask

   task automatic test_backpressure;
      int  acc;
      bit  r;
      q.delete();
      req_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         stamp_valid = 1'b1;
         stamp_data  = sd(30 + acc);
         stamp_mask  = mk(30 + acc);
         r = stamp_ready;
         if (c == 6) begin
            tests++;
            if (req_data !== grp(30, 4)) begin fails++; $display("FAIL bp_mid_data got %h exp %h", req_data, grp(30, 4)); end
         end
         @(negedge clk);
         if (r) acc++;
      end
      tests++; if (acc !== 8) begin fails++; $display("FAIL bp_accepted got %0d exp 8", acc); end
      tests++; if (stamp_ready !== 1'b0) begin fails++; $display("FAIL bp_stamp_ready got %b exp 0", stamp_ready); end
      tests++; if (req_valid !== 1'b1 || req_data !== grp(30, 4)) begin
         fails++; $display("FAIL bp_hold got v%b %h exp v1 %h", req_valid, req_data, grp(30, 4));
      end
      req_ready = 1'b1;
      push_stamp(30 + acc);
      stamp_valid = 1'b0;
      stamps_end  = 1'b1;
      wait_q(4);
      req_ready = 1'b0;
      if (q.size() >= 4) begin
         tests++; if (q[0].d !== grp(30, 4) || q[0].m !== gmask(30, 4)) begin fails++; $display("FAIL bp_req0 got %h/%h", q[0].d, q[0].m); end
         tests++; if (q[1].d !== grp(34, 4) || q[1].m !== gmask(34, 4)) begin fails++; $display("FAIL bp_req1 got %h/%h", q[1].d, q[1].m); end
         tests++; if (q[2].d !== grp(38, 1) || q[2].m !== gmask(38, 1) || q[2].dn !== 1'b0) begin
            fails++; $display("FAIL bp_req2 got %h/%h/%b exp %h/%h/0", q[2].d, q[2].m, q[2].dn, grp(38, 1), gmask(38, 1));
         end
         tests++; if (q[3].dn !== 1'b1) begin fails++; $display("FAIL bp_done got %b exp 1", q[3].dn); end
      end
   endtask

   task automatic test_end_empty;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      req_ready  = 1'b0;
      stamps_end = 1'b1;
      @(negedge clk);
      tests++; if (req_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL empty_flush got v%b busy%b exp v0 busy1", req_valid, busy); end
      @(negedge clk);
      tests++;
      if (req_valid !== 1'b1 || req_done !== 1'b1 || req_mask !== 16'h0) begin
         fails++; $display("FAIL empty_done got v%b d%b m%h exp v1 d1 m0", req_valid, req_done, req_mask);
      end
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      tests++;
      if (q.size() < 1 || q[0].dn !== 1'b1 || q[0].m !== 16'h0) begin
         fails++; $display("FAIL empty_first_req got size%0d, required first request done=1 mask=0", q.size());
      end
   endtask

   task automatic test_reset_mid;
      reset = 1'b1;
      stamps_end = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      req_ready = 1'b0;
      for (int k = 40; k < 46; k++) push_stamp(k);
      stamp_valid = 1'b0;
      tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid got %b exp 1", req_valid); end
      reset = 1'b1;
      #1;
      tests++;
      if (req_valid !== 1'b0 || req_done !== 1'b0 || busy !== 1'b1 || stamp_ready !== 1'b1 || req_mask !== 16'h0) begin
         fails++; $display("FAIL mid_async got v%b d%b busy%b rdy%b m%h exp v0 d0 busy1 rdy1 m0", req_valid, req_done, busy, stamp_ready, req_mask);
      end
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      req_ready = 1'b1;
      push_stamp(50);
      stamp_valid = 1'b0;
      stamps_end  = 1'b1;
      wait_q(2);
      if (q.size() >= 2) begin
         tests++;
         if (q[0].d !== grp(50, 1) || q[0].m !== gmask(50, 1) || q[0].dn !== 1'b0) begin
            fails++; $display("FAIL mid_stale got %h/%h/%b exp %h/%h/0", q[0].d, q[0].m, q[0].dn, grp(50, 1), gmask(50, 1));
         end
         tests++; if (q[1].dn !== 1'b1) begin fails++; $display("FAIL mid_done got %b exp 1", q[1].dn); end
      end
   endtask

   initial begin
      test_reset;
      test_back_to_back;
      test_flush;
      test_done_repeat;
      test_restart;
      test_backpressure;
      test_end_empty;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
